// File: rtl/display_scan_driver.sv
`timescale 1ns/1ps
// display_scan_driver
// Time-multiplexed driver for a two-digit common-anode seven-segment display.
// A captured 4-bit value (0-15) is split into a tens flag and a units digit.
// The two anodes alternate every REFRESH_DIV clocks, and every switch is
// separated by one fully blanked guard cycle so no ghosting reaches the
// other digit. All outputs come straight from flops.
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       load,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       slot
);

  localparam int               CNT_W     = 24;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [1:0]       AN_OFF    = 2'b11;
  localparam logic [1:0]       AN_UNITS  = 2'b10;
  localparam logic [1:0]       AN_TENS   = 2'b01;

  typedef enum logic {
    ST_UNITS = 1'b0,
    ST_TENS  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic             tick;
  logic             tensDigit;
  logic [3:0]       unitsDigit;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] encDigit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Split the captured value into tens (0 or 1) and units (0-9); both digits
  // always come from the same capture so the display is never torn.
  always_comb begin
    tensDigit  = (cap_q >= 4'd10);
    unitsDigit = tensDigit ? (cap_q - 4'd10) : cap_q;
  end

  // Refresh timing: tick marks the last cycle of a slot and is the guard cycle.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
    cap_d = load ? value : cap_q;
  end

  // Next slot and next anode/segment drive; the guard blanks on every switch.
  always_comb begin
    state_d = state_q;
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    if (tick) begin
      state_d = (state_q == ST_UNITS) ? ST_TENS : ST_UNITS;
    end else if (state_q == ST_UNITS) begin
      an_d  = AN_UNITS;
      seg_d = encDigit(unitsDigit);
    end else if (!(BLANK_LEADING && !tensDigit)) begin
      an_d  = AN_TENS;
      seg_d = encDigit({3'b000, tensDigit});
    end
  end

  // Scan FSM plus capture, counter and output registers; reset blanks at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNITS;
      cap_q   <= 4'd0;
      cnt_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign slot = (state_q == ST_TENS);

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Drives a two-digit, common-anode seven-segment display from a 4-bit binary value (0–15) produced by the decoder. It splits the captured value into units and tens, alternates the two anodes at a fixed refresh rate with a one-cycle blanking guard at every switch, and encodes the active digit onto the shared segment bus. It is the anode/segment-driving end of the digit-enable interface used by the display control logic.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot; legal range 2 to 2^24-1.
- BLANK_LEADING, default 1: 1 = blank the tens digit when it is 0.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  4  binary value to display, 0–15.
- load  in  1  capture `value` on this rising clk edge.
- an  out  2  anode enables, active-low: an[0] = units, an[1] = tens.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- slot  out  1  current slot: 0 = units, 1 = tens.

## Operation
- Capture register `cap[3:0]`: loads `value` when `load`=1, otherwise holds; reset to 0. Both digits always derive from the same `cap`, so there is no torn display.
- BCD split, combinational on `cap`:
  - tens = (cap ≥ 10);
  - units = tens ? cap−10 : cap (4-bit, range 0–9).
- Refresh counter `cnt`: counts 0..REFRESH_DIV−1 and wraps to 0. `tick` = (cnt == REFRESH_DIV−1). Reset to 0.
- FSM, two states:
  - UNITS (reset state) goes to TENS on `tick`.
  - TENS goes to UNITS on `tick`.
  - No other transitions.
- `slot` is the registered FSM state.
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Registered outputs, updated every edge:
  - If `tick` this cycle: an<=11, seg<=1111111 (guard).
  - Else in UNITS: an<=10, seg<=enc(units).
  - Else in TENS: an<=01, seg<=enc(tens), unless BLANK_LEADING=1 and tens=0, in which case an<=11 and seg<=1111111.
- Reset (async, any time, including mid-slot): an=11, seg=1111111, slot=0, cnt=0, cap=0, all immediate.
- `load` and `tick` in the same cycle: both take effect. The next lit cycle uses the new `cap`.

## Timing
- Capture latency: `load` at edge N, so cap is valid after N. `seg` reflects it after edge N+1 (one cycle), provided no guard cycle occurs at N+1.
- Slot length is REFRESH_DIV cycles: 1 guard cycle plus REFRESH_DIV−1 lit cycles. The full scan period is 2·REFRESH_DIV cycles.
- After reset release:
  - First edge drives an=10 with seg=enc(0)=1000000.
  - `slot` changes on the same edge on which `an` goes 11.
- `an` never has both bits 0 in any cycle, and never switches directly 10↔01 without an 11 cycle between.
- Values 10–15 show "1" plus units 0–5. All `value` inputs are legal; there are no invalid encodings.

## Test plan
- Reset, then REFRESH_DIV=4, BLANK_LEADING=1, load value=7 → units slot shows an=10, seg=1111000. Tens slot shows an=11, seg=1111111 (blanked zero). Guard cycle every 4th edge.
- load value=13 → units slot shows an=10, seg=0110000 ("3"). Tens slot shows an=01, seg=1111001 ("1"). Scan period 8 cycles, exactly 3 lit cycles per slot.
- BLANK_LEADING=0, value=5 → tens slot shows an=01, seg=1000000 ("0").
- Assert `load` (value 9→12) on the same edge as `tick` → the next lit cycle uses cap=12. No lit cycle ever shows units from 9 with tens from 12.
- Assert rst asynchronously mid-TENS slot, between clock edges → an=11, seg=1111111, slot=0 immediately. After release: an=10, seg=1000000, and the counter restarts from 0.
- Sweep value 0–15 with REFRESH_DIV=2 → every cycle alternates guard/lit. Check the both-anodes-low assertion is never hit, and the segment patterns match the table for all 16 values.
